// File: rtl/jt900h_memarb_if.sv
// Requester and external bus signals of the TLCS-900H memory arbiter.
// slave = arbiter side, master = requesters plus external memory.
interface jt900h_memarb_if;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_sz;
  logic [23:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_busy;
  logic [23:0] bus_addr;
  logic [15:0] bus_dout;
  logic [15:0] bus_din;
  logic        bus_rd;
  logic        bus_wr;
  logic [1:0]  bus_be;
  logic        bus_rdy;
  logic [1:0]  wait_cfg;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_sz, data_addr, data_wdata,
           bus_din, bus_rdy, wait_cfg,
    output fetch_ack, fetch_data, data_rdata, data_ack, mem_busy,
           bus_addr, bus_dout, bus_rd, bus_wr, bus_be
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_sz, data_addr, data_wdata,
           bus_din, bus_rdy, wait_cfg,
    input  fetch_ack, fetch_data, data_rdata, data_ack, mem_busy,
           bus_addr, bus_dout, bus_rd, bus_wr, bus_be
  );
endinterface

// File: rtl/jt900h_memarb.sv
// Arbiter between instruction prefetch and microcode data accesses on a 16-bit bus.
// Define JT900H_MEMARB_WAITST_EN to add wait_cfg wait states per beat.
module jt900h_memarb (
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  jt900h_memarb_if.slave m
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
`ifdef JT900H_MEMARB_WAITST_EN
    WAIT,
`endif
    DONE
  } state_t;

  state_t      state, state_nx, beat_first;
  logic [2:0]  loss;
  logic        is_fetch, we_l;
  logic [23:0] cur_addr;
  logic [2:0]  rem, pos, sz_bytes;
  logic [31:0] wdata_l, acc, rdata_r, ins, rd_next;
  logic [15:0] fdata_r, wsh, dout;
  logic [7:0]  lo_byte;
  logic [1:0]  beat_len, be_calc;
  logic        grant_data, grant_fetch, beat_done, active;
  logic        beat_odd, beat_word, last_beat;
`ifdef JT900H_MEMARB_WAITST_EN
  logic [1:0]  wait_cnt;
`else
  logic        unused_wait;
  assign unused_wait = ^m.wait_cfg;
`endif

  // Beat shape derives from the remaining byte count and current alignment:
  // odd address -> upper byte, even with >=2 left -> word, else lower byte.
  always_comb begin
    beat_odd  = cur_addr[0];
    beat_word = !beat_odd && (rem >= 3'd2);
    beat_len  = beat_word ? 2'd2 : 2'd1;
    be_calc   = beat_odd ? 2'b10 : (beat_word ? 2'b11 : 2'b01);
    last_beat = (rem == {1'b0, beat_len});
    lo_byte   = beat_odd ? m.bus_din[15:8] : m.bus_din[7:0];
    ins       = beat_word ? {16'd0, m.bus_din} : {24'd0, lo_byte};
    rd_next   = acc | (ins << {pos, 3'b000});
    wsh       = 16'(wdata_l >> {pos, 3'b000});
    case (be_calc)
      2'b10:   dout = {wsh[7:0], 8'h00};
      2'b11:   dout = wsh;
      default: dout = {8'h00, wsh[7:0]};
    endcase
    case (m.data_sz)
      2'b10:   sz_bytes = 3'd2;
      2'b11:   sz_bytes = 3'd4;
      default: sz_bytes = 3'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    beat_done   = 1'b0;
`ifdef JT900H_MEMARB_WAITST_EN
    beat_first  = (m.wait_cfg != 2'd0) ? WAIT : BEAT;
`else
    beat_first  = BEAT;
`endif
    case (state)
      IDLE: if (cen) begin
        if (m.data_req && !(m.fetch_req && loss == 3'd4)) grant_data = 1'b1;
        else if (m.fetch_req)                             grant_fetch = 1'b1;
        if (grant_data || grant_fetch) state_nx = beat_first;
      end
`ifdef JT900H_MEMARB_WAITST_EN
      WAIT: if (cen && wait_cnt == 2'd1) state_nx = BEAT;
`endif
      BEAT: if (cen && m.bus_rdy) begin
        beat_done = 1'b1;
        state_nx  = last_beat ? DONE : beat_first;
      end
      DONE: if (cen) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss     <= 3'd0;
      is_fetch <= 1'b0;
      we_l     <= 1'b0;
      cur_addr <= 24'd0;
      rem      <= 3'd0;
      pos      <= 3'd0;
      wdata_l  <= 32'd0;
      acc      <= 32'd0;
      rdata_r  <= 32'd0;
      fdata_r  <= 16'd0;
`ifdef JT900H_MEMARB_WAITST_EN
      wait_cnt <= 2'd0;
`endif
    end else if (cen) begin
      if (!m.fetch_req || grant_fetch)       loss <= 3'd0;
      else if (grant_data && loss != 3'd4)   loss <= loss + 3'd1;
      if (grant_data) begin
        cur_addr <= m.data_addr;
        rem      <= sz_bytes;
        we_l     <= m.data_we;
        wdata_l  <= m.data_wdata;
        is_fetch <= 1'b0;
        pos      <= 3'd0;
        acc      <= 32'd0;
      end
      if (grant_fetch) begin
        cur_addr <= m.fetch_addr;
        rem      <= 3'd2;
        we_l     <= 1'b0;
        is_fetch <= 1'b1;
        pos      <= 3'd0;
        acc      <= 32'd0;
      end
`ifdef JT900H_MEMARB_WAITST_EN
      if (state_nx == WAIT && state != WAIT) wait_cnt <= m.wait_cfg;
      else if (state == WAIT)                wait_cnt <= wait_cnt - 2'd1;
`endif
      if (beat_done) begin
        cur_addr <= cur_addr + {22'd0, beat_len};
        rem      <= rem - {1'b0, beat_len};
        pos      <= pos + {1'b0, beat_len};
        acc      <= rd_next;
        if (last_beat && !we_l) begin
          if (is_fetch) fdata_r <= rd_next[15:0];
          else          rdata_r <= rd_next;
        end
      end
    end
  end

  always_comb begin
    active = (state == BEAT);
`ifdef JT900H_MEMARB_WAITST_EN
    if (state == WAIT) active = 1'b1;
`endif
  end

  // Strobes are decoded from the state register so reset drops them at once.
  assign m.bus_rd     = active & ~we_l;
  assign m.bus_wr     = active & we_l;
  assign m.bus_be     = active ? be_calc : 2'b00;
  assign m.bus_addr   = {cur_addr[23:1], 1'b0};
  assign m.bus_dout   = dout;
  assign m.data_ack   = (state == DONE) & ~is_fetch;
  assign m.fetch_ack  = (state == DONE) & is_fetch;
  assign m.data_rdata = rdata_r;
  assign m.fetch_data = fdata_r;
  assign m.mem_busy   = m.data_req | (active & ~is_fetch);

endmodule

// File: tb/tb_jt900h_memarb.sv
// Scoreboard bench for jt900h_memarb: expected beats and acks are queued at issue
// and popped by a monitor as the bus and ack outputs appear.
module tb_jt900h_memarb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen = 1'b1;

  jt900h_memarb_if m();

  jt900h_memarb u_dut (
    .rst (rst),
    .clk (clk),
    .cen (cen),
    .m   (m.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [1:0]  be;
    logic [15:0] dout;
    logic        wr;
  } beat_t;

  typedef struct {
    logic        is_fetch;
    logic        chk_data;
    logic [31:0] data;
  } ack_t;

  beat_t exp_beat[$];
  ack_t  exp_ack[$];
  logic [7:0] mem [logic [23:0]];

  int   n_chk = 0;
  int   n_err = 0;
  int   ack_cnt = 0;
  int   strobe_cens = 0;
  bit   rnd_cen = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic prev_strobe = 1'b0;
  logic [23:0] prev_addr = 24'd0;
  logic  mon_s;
  beat_t mon_b;
  ack_t  mon_a;
  logic [15:0] mon_mask;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  task automatic push_beat(logic [23:0] a, logic [1:0] be, logic [15:0] d, logic wr);
    beat_t b;
    b.addr = {a[23:1], 1'b0};
    b.be   = be;
    b.dout = d;
    b.wr   = wr;
    exp_beat.push_back(b);
  endtask

  task automatic plan(logic we, logic [1:0] sz, logic [23:0] a, logic [31:0] wd);
    logic [7:0] b0, b1, b2, b3;
    ack_t k;
    int n;
    b0 = wd[7:0]; b1 = wd[15:8]; b2 = wd[23:16]; b3 = wd[31:24];
    case ({sz, a[0]})
      3'b010: push_beat(a, 2'b01, {8'h00, b0}, we);
      3'b011: push_beat(a, 2'b10, {b0, 8'h00}, we);
      3'b100: push_beat(a, 2'b11, {b1, b0}, we);
      3'b101: begin
        push_beat(a,          2'b10, {b0, 8'h00}, we);
        push_beat(a + 24'd1,  2'b01, {8'h00, b1}, we);
      end
      3'b110: begin
        push_beat(a,          2'b11, {b1, b0}, we);
        push_beat(a + 24'd2,  2'b11, {b3, b2}, we);
      end
      3'b111: begin
        push_beat(a,          2'b10, {b0, 8'h00}, we);
        push_beat(a + 24'd1,  2'b11, {b2, b1}, we);
        push_beat(a + 24'd3,  2'b01, {8'h00, b3}, we);
      end
      default: ;
    endcase
    n = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
    k.is_fetch = 1'b0;
    k.chk_data = !we;
    k.data = 32'd0;
    for (int i = 0; i < n; i++) k.data |= 32'(rd_byte(a + 24'(i))) << (8 * i);
    exp_ack.push_back(k);
  endtask

  task automatic plan_fetch(logic [23:0] a);
    ack_t k;
    push_beat(a, 2'b11, 16'h0000, 1'b0);
    k.is_fetch = 1'b1;
    k.chk_data = 1'b1;
    k.data = {16'd0, rd_byte(a + 24'd1), rd_byte(a)};
    exp_ack.push_back(k);
  endtask

  task automatic wait_acks(int target, string tag);
    for (int i = 0; i < 400 && ack_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, ack_cnt, target);
  endtask

  task automatic do_data(logic we, logic [1:0] sz, logic [23:0] a, logic [31:0] wd);
    int t;
    t = ack_cnt + 1;
    plan(we, sz, a, wd);
    m.data_we = we; m.data_sz = sz; m.data_addr = a; m.data_wdata = wd;
    m.data_req = 1'b1;
    for (int i = 0; i < 100 && !(m.bus_rd | m.bus_wr); i++) begin
      @(posedge clk); #1;
    end
    m.data_req = 1'b0;
    chk("busy_owned", m.mem_busy, 1);
    wait_acks(t, "data_ack_cnt");
    chk("busy_idle", m.mem_busy, 0);
  endtask

  // Bus model and randomised cen / ready, updated just after each clock edge.
  always @(posedge clk) begin
    #1;
    cen       = rnd_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
    m.bus_rdy = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    m.bus_din = {rd_byte(m.bus_addr | 24'd1), rd_byte(m.bus_addr & 24'hFFFFFE)};
  end

  always @(negedge clk) begin
    if (rst) prev_strobe = 1'b0;
    else if (cen) begin
      mon_s = m.bus_rd | m.bus_wr;
      if (mon_s) strobe_cens++;
      if (mon_s && !(prev_strobe && m.bus_addr == prev_addr)) begin
        if (exp_beat.size() == 0) chk("beat_queue", exp_beat.size(), 1);
        else begin
          mon_b = exp_beat.pop_front();
          chk("beat_addr", m.bus_addr, mon_b.addr);
          chk("beat_be", m.bus_be, mon_b.be);
          chk("beat_wr", m.bus_wr, mon_b.wr);
          if (mon_b.wr) begin
            mon_mask = {{8{mon_b.be[1]}}, {8{mon_b.be[0]}}};
            chk("beat_dout", m.bus_dout & mon_mask, mon_b.dout & mon_mask);
          end
        end
      end
      prev_strobe = mon_s;
      prev_addr   = m.bus_addr;
      if (m.data_ack | m.fetch_ack) begin
        ack_cnt++;
        if (exp_ack.size() == 0) chk("ack_queue", exp_ack.size(), 1);
        else begin
          mon_a = exp_ack.pop_front();
          chk("ack_kind", {30'd0, m.fetch_ack, m.data_ack}, mon_a.is_fetch ? 32'd2 : 32'd1);
          if (mon_a.chk_data) begin
            if (mon_a.is_fetch) chk("fetch_data", {16'd0, m.fetch_data}, mon_a.data);
            else                chk("data_rdata", m.data_rdata, mon_a.data);
          end
        end
      end
    end
  end

  initial begin
    int t;
    mem[24'h000100] = 8'h12;
    mem[24'h000101] = 8'hAB;
    m.fetch_req = 1'b0; m.fetch_addr = 24'd0;
    m.data_req = 1'b0; m.data_we = 1'b0; m.data_sz = 2'b01;
    m.data_addr = 24'd0; m.data_wdata = 32'd0;
    m.bus_din = 16'd0; m.bus_rdy = 1'b1; m.wait_cfg = 2'd0;

    #1 rst = 1'b1;
    #2;
    chk("rst_bus_rd", m.bus_rd, 0);
    chk("rst_bus_wr", m.bus_wr, 0);
    chk("rst_bus_be", m.bus_be, 0);
    chk("rst_bus_addr", m.bus_addr, 0);
    chk("rst_bus_dout", m.bus_dout, 0);
    chk("rst_data_rdata", m.data_rdata, 0);
    chk("rst_fetch_data", m.fetch_data, 0);
    chk("rst_acks", {m.data_ack, m.fetch_ack}, 0);
    chk("rst_mem_busy", m.mem_busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_data(1'b0, 2'b01, 24'h000101, 32'd0);
    do_data(1'b0, 2'b01, 24'h000100, 32'd0);
    do_data(1'b1, 2'b11, 24'h000201, 32'h44332211);
    do_data(1'b1, 2'b10, 24'h000410, 32'h0000BEEF);
    do_data(1'b0, 2'b10, 24'h000333, 32'd0);
    do_data(1'b0, 2'b11, 24'h000600, 32'd0);

    t = ack_cnt + 1;
    plan_fetch(24'h0009A0);
    m.fetch_addr = 24'h0009A0;
    m.fetch_req = 1'b1;
    for (int i = 0; i < 100 && !m.bus_rd; i++) begin
      @(posedge clk); #1;
    end
    m.fetch_req = 1'b0;
    chk("busy_fetch", m.mem_busy, 0);
    wait_acks(t, "fetch_ack_cnt");

    // Continuous contention: four data grants, then one forced fetch.
    m.data_we = 1'b0; m.data_sz = 2'b10; m.data_addr = 24'h000400;
    m.fetch_addr = 24'h000800;
    t = ack_cnt + 11;
    for (int k = 0; k < 11; k++) begin
      if (k % 5 == 4) plan_fetch(24'h000800);
      else            plan(1'b0, 2'b10, 24'h000400, 32'd0);
    end
    m.data_req = 1'b1; m.fetch_req = 1'b1;
    wait_acks(t, "arb_acks");
    m.data_req = 1'b0; m.fetch_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("arb_no_extra", ack_cnt, t);

    m.wait_cfg = 2'd2;
    strobe_cens = 0;
    do_data(1'b0, 2'b10, 24'h000500, 32'd0);
`ifdef JT900H_MEMARB_WAITST_EN
    chk("wait_strobe_cens", strobe_cens, 3);
`else
    chk("wait_strobe_cens", strobe_cens, 1);
`endif
    m.wait_cfg = 2'd0;

    do_data(1'b0, 2'b10, 24'hFFFFFF, 32'd0);

    // Reset during the second beat of a long read.
    push_beat(24'h000300, 2'b11, 16'h0000, 1'b0);
    t = ack_cnt;
    m.data_we = 1'b0; m.data_sz = 2'b11; m.data_addr = 24'h000300;
    m.data_req = 1'b1;
    for (int i = 0; i < 100 && !(m.bus_rd && m.bus_addr == 24'h000302); i++) begin
      @(posedge clk); #1;
      if (m.bus_rd | m.bus_wr) m.data_req = 1'b0;
    end
    chk("rst_beat2_addr", m.bus_addr, 24'h000302);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_rd", m.bus_rd, 0);
    chk("rst_mid_be", m.bus_be, 0);
    chk("rst_mid_busy", m.mem_busy, 0);
    m.data_req = 1'b1;
    #1 chk("rst_mid_busy_req", m.mem_busy, 1);
    m.data_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst_no_ack", ack_cnt, t);
    do_data(1'b0, 2'b10, 24'h000300, 32'd0);

    rnd_cen = 1'b1; rnd_rdy = 1'b1;
    do_data(1'b0, 2'b10, 24'h000201, 32'd0);
    do_data(1'b1, 2'b11, 24'h000600, 32'hDEADBEEF);
    do_data(1'b1, 2'b01, 24'h000123, 32'h000000A5);
    do_data(1'b0, 2'b11, 24'h000701, 32'd0);
    do_data(1'b1, 2'b10, 24'h000455, 32'h00007E81);
    do_data(1'b0, 2'b01, 24'h000101, 32'd0);
    rnd_cen = 1'b0; rnd_rdy = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("beats_left", exp_beat.size(), 0);
    chk("acks_left", exp_ack.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/jt900h_memarb.md
JT900H_MEMARB -- requirements
Module: jt900h_memarb

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  clock.
- cen  in  1  clock enable; all state advances only when cen=1.
- fetch_req  in  1  instruction prefetch request.
- fetch_addr  in  24  fetch address; always even.
- fetch_ack  out  1  one-cen pulse; fetch_data valid.
- fetch_data  out  16  fetched word.
- data_req  in  1  microcode data access request.
- data_we  in  1  1=write, 0=read.
- data_sz  in  2  access size: 01=byte, 10=word, 11=long.
- data_addr  in  24  byte address.
- data_wdata  in  32  write data, LSB-first.
- data_rdata  out  32  read data, zero-filled above the access size.
- data_ack  out  1  one-cen pulse at access completion.
- mem_busy  out  1  high while a data access is pending or in progress; feeds the controller stall.
- bus_addr  out  24  external address, even-aligned.
- bus_dout  out  16  external write data.
- bus_din  in  16  external read data.
- bus_rd  out  1  read strobe.
- bus_wr  out  1  write strobe.
- bus_be  out  2  byte enables ([0]=even byte, [1]=odd byte).
- bus_rdy  in  1  external ready, sampled on cen.
- wait_cfg  in  2  wait states added per beat.

Function
REQ-002 SHALL use an FSM with states IDLE, BEAT, WAIT and DONE.
REQ-003 In IDLE, on cen, SHALL grant data_req over fetch_req, except when fetch_req has lost 4 consecutive arbitrations; the fetch is then granted once and the loss counter clears.
REQ-004 The loss counter SHALL be 3 bits, saturate at 4, and clear on any fetch grant or when fetch_req=0.
REQ-005 A grant SHALL latch the address, size, we and wdata; requester inputs are ignored until DONE.
REQ-006 A data access SHALL be split into beats:
- byte: 1 beat; lane = addr[0].
- word at even addr: 1 beat, be=11.
- word at odd addr: 2 byte beats.
- long at even addr: 2 word beats.
- long at odd addr: 3 beats: byte, word, byte.
REQ-007 Each beat SHALL assert bus_rd or bus_wr with bus_addr = {addr[23:1],0} for that beat.
REQ-008 A beat SHALL complete on the first cen where the wait count has expired and bus_rdy=1; strobes stay asserted until then.
REQ-009 Beat addresses SHALL increment modulo 2^24; 24'hFFFFFF+1 wraps to 0.
REQ-010 Read bytes SHALL be assembled into data_rdata in address order, LSB first; writes SHALL place each byte on its lane.
REQ-011 DONE SHALL last one cen:
- pulse data_ack or fetch_ack;
- update data_rdata or fetch_data;
- return to IDLE.
The next grant may occur on the following cen.
REQ-012 A fetch SHALL be a single word read beat.
REQ-013 mem_busy SHALL equal data_req OR (a data access is owned and DONE has not been reached).
REQ-014 Simultaneous data_req and fetch_req with the loss counter below 4 SHALL grant the data access and increment the loss counter.
REQ-015 When cen=0, outputs SHALL hold and acks SHALL not re-pulse.

Reset
REQ-016 Reset SHALL set:
- FSM = IDLE;
- all strobes, acks and bus_be = 0;
- bus_addr, bus_dout, data_rdata, fetch_data = 0;
- loss counter = 0.
REQ-017 Reset asserted mid-access SHALL abort the access immediately, with no ack pulse; bus strobes drop asynchronously.

Configuration
REQ-018 Macro JT900H_MEMARB_WAITST_EN:
- Defined: each beat SHALL insert wait_cfg extra cen cycles (WAIT state, 2-bit down-counter) before bus_rdy is honoured.
- Undefined: wait_cfg SHALL be ignored, the WAIT state removed, and beats complete as soon as bus_rdy=1.

Verification
REQ-019 Byte read at 24'h000101, bus_din=16'hAB12, bus_rdy=1, wait_cfg=0 -> single beat with be=10; data_rdata=32'h000000AB; data_ack 1 pulse.
REQ-020 Long write of 32'h44332211 at 24'h000201 -> 3 beats:
- addr 200, be=10, dout[15:8]=11;
- addr 202, be=11, dout=3322;
- addr 204, be=01, dout[7:0]=44.
REQ-021 data_req held high continuously with fetch_req=1 -> 4 data grants, then 1 fetch grant, then data resumes; fetch_ack seen exactly once per 5 grants.
REQ-022 With macro defined, wait_cfg=2 and a word read -> strobe held 3 cens; with macro undefined, held 1 cen.
REQ-023 Word read at 24'hFFFFFF -> beats at FFFFFE then 000000; no X on the bus.
REQ-024 rst pulsed during the second beat of a long read -> strobes 0 immediately, no data_ack, FSM=IDLE, mem_busy follows data_req.
